// File: rtl/stream_mux_rr.sv
// rtl/stream_mux_rr.sv - N:1 valid/ready stream mux with rr/fixed-priority arbiter and registered output; optional packet lock via STREAM_MUX_PKT_LOCK_EN
module stream_mux_rr #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 8,
    parameter int ARB_MODE = 0,
    localparam int SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic [NUM_CH*DATA_W-1:0] In_data,
    input  logic [NUM_CH-1:0]        In_valid,
    input  logic [NUM_CH-1:0]        In_last,
    output logic [NUM_CH-1:0]        In_ready,
    output logic [DATA_W-1:0]        Out_data,
    output logic                     Out_valid,
    output logic                     Out_last,
    output logic [SEL_W-1:0]         Out_sel,
    input  logic                     Out_ready
);

    logic              load_en;
    logic              grant_vld;
    logic [SEL_W-1:0]  grant_idx;
    logic [DATA_W-1:0] grant_data;
    logic              grant_last;
    logic              grant_in_valid;
    logic              xfer;
    logic              ptr_adv;
    logic [SEL_W-1:0]  rr_ptr;

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic              lock;
    logic [SEL_W-1:0]  lock_ch;
`endif

    function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_CH) begin
            sum = sum - NUM_CH;
        end
        return sum[SEL_W-1:0];
    endfunction

    // Descending scan so the last write is the lowest offset that has a valid beat.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (ARB_MODE == 1) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (In_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int j = NUM_CH - 1; j >= 0; j--) begin
                if (In_valid[wrap_idx(rr_ptr, j)]) begin
                    grant_vld = 1'b1;
                    grant_idx = wrap_idx(rr_ptr, j);
                end
            end
        end
`ifdef STREAM_MUX_PKT_LOCK_EN
        // A packet in flight owns the output even while its producer idles.
        if (lock) begin
            grant_vld = 1'b1;
            grant_idx = lock_ch;
        end
`endif
    end

    always_comb begin
        grant_data     = '0;
        grant_last     = 1'b0;
        grant_in_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                grant_data     = In_data[i*DATA_W +: DATA_W];
                grant_last     = In_last[i];
                grant_in_valid = In_valid[i];
            end
        end
    end

    assign load_en = ~Out_valid | Out_ready;

    always_comb begin
        In_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            In_ready[i] = grant_vld & load_en & ~Rst & (grant_idx == SEL_W'(i));
        end
    end

    assign xfer = grant_vld & grant_in_valid & load_en & ~Rst;

`ifdef STREAM_MUX_PKT_LOCK_EN
    assign ptr_adv = grant_last;
`else
    assign ptr_adv = 1'b1;
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Out_valid <= 1'b0;
            Out_data  <= '0;
            Out_last  <= 1'b0;
            Out_sel   <= '0;
        end else if (xfer) begin
            Out_valid <= 1'b1;
            Out_data  <= grant_data;
            Out_last  <= grant_last;
            Out_sel   <= grant_idx;
        end else if (Out_ready) begin
            Out_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rr_ptr <= '0;
        end else if ((ARB_MODE == 0) && xfer && ptr_adv) begin
            rr_ptr <= wrap_idx(grant_idx, 1);
        end
    end

`ifdef STREAM_MUX_PKT_LOCK_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            lock    <= 1'b0;
            lock_ch <= '0;
        end else if (xfer) begin
            lock    <= ~grant_last;
            lock_ch <= grant_idx;
        end
    end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb/tb_stream_mux_rr.sv - self-checking bench for stream_mux_rr (round-robin and fixed-priority instances)
module tb_stream_mux_rr;
    localparam int N = 4;
    localparam int W = 8;
`ifdef STREAM_MUX_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Rst;
    logic [N*W-1:0] in_data;
    logic [N-1:0] in_valid;
    logic [N-1:0] in_last;
    logic         out_ready;

    logic [N-1:0] d_ready [2];
    logic         d_valid [2];
    logic [W-1:0] d_data  [2];
    logic         d_last  [2];
    logic [1:0]   d_sel   [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state, index 0 = round-robin instance, 1 = fixed-priority instance
    int           m_ptr   [2];
    bit           m_lock  [2];
    int           m_lch   [2];
    bit           m_valid [2];
    logic [W-1:0] m_data  [2];
    bit           m_last  [2];
    logic [1:0]   m_sel   [2];
    logic [N-1:0] e_ready [2];
    bit           e_xfer  [2];
    int           e_g     [2];
    bit           acc_ok;
    int           acc_ch;

    stream_mux_rr #(.NUM_CH(N), .DATA_W(W), .ARB_MODE(0)) u_rr (
        .Clk(Clk), .Rst(Rst), .In_data(in_data), .In_valid(in_valid), .In_last(in_last),
        .In_ready(d_ready[0]), .Out_data(d_data[0]), .Out_valid(d_valid[0]),
        .Out_last(d_last[0]), .Out_sel(d_sel[0]), .Out_ready(out_ready)
    );

    stream_mux_rr #(.NUM_CH(N), .DATA_W(W), .ARB_MODE(1)) u_fp (
        .Clk(Clk), .Rst(Rst), .In_data(in_data), .In_valid(in_valid), .In_last(in_last),
        .In_ready(d_ready[1]), .Out_data(d_data[1]), .Out_valid(d_valid[1]),
        .Out_last(d_last[1]), .Out_sel(d_sel[1]), .Out_ready(out_ready)
    );

    always #5 Clk = ~Clk;

    task automatic model_eval();
        for (int m = 0; m < 2; m++) begin
            bit load;
            bit gv;
            int g;
            load = !m_valid[m] || out_ready;
            gv = 1'b0;
            g = 0;
            if (m_lock[m]) begin
                gv = 1'b1;
                g = m_lch[m];
            end else begin
                for (int j = 0; j < N; j++) begin
                    int c;
                    c = (m == 1) ? j : (m_ptr[m] + j) % N;
                    if (!gv && in_valid[c]) begin
                        gv = 1'b1;
                        g = c;
                    end
                end
            end
            e_g[m]     = g;
            e_ready[m] = (gv && load && !Rst) ? N'(1 << g) : '0;
            e_xfer[m]  = gv && load && !Rst && in_valid[g];
        end
    endtask

    task automatic model_commit();
        for (int m = 0; m < 2; m++) begin
            if (Rst) begin
                m_ptr[m] = 0; m_lock[m] = 1'b0; m_lch[m] = 0;
                m_valid[m] = 1'b0; m_data[m] = '0; m_last[m] = 1'b0; m_sel[m] = '0;
            end else if (e_xfer[m]) begin
                int g;
                g = e_g[m];
                m_valid[m] = 1'b1;
                m_data[m]  = in_data[g*W +: W];
                m_last[m]  = in_last[g];
                m_sel[m]   = 2'(g);
                if (m == 0 && (!LOCK_EN || in_last[g])) m_ptr[m] = (g + 1) % N;
                if (LOCK_EN) begin
                    m_lock[m] = !in_last[g];
                    m_lch[m]  = g;
                end
            end else if (out_ready) begin
                m_valid[m] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        model_eval();
        acc_ok = e_xfer[0];
        acc_ch = e_g[0];
        @(posedge Clk);
        model_commit();
        #2;
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] d, input bit v, input bit l);
        in_data[c*W +: W] = d;
        in_valid[c] = v;
        in_last[c]  = l;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        in_valid = '0;
        tick();
        tick();
        Rst = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; in_valid = '1; in_last = '1; out_ready = 1'b1;
        for (int c = 0; c < N; c++) in_data[c*W +: W] = W'(8'h30 + c);
        for (int k = 0; k < 2; k++) begin
            tick();
            for (int m = 0; m < 2; m++) begin
                n_checks++; if (d_ready[m] !== 4'b0000) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b want 0000", m, d_ready[m]); end
                n_checks++; if (d_valid[m] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", m, d_valid[m]); end
                n_checks++; if (d_data[m] !== 8'h00) begin n_fail++; $display("FAIL reset_data[%0d]: got %h want 00", m, d_data[m]); end
                n_checks++; if (d_sel[m] !== 2'd0) begin n_fail++; $display("FAIL reset_sel[%0d]: got %0d want 0", m, d_sel[m]); end
            end
        end
        Rst = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            n_checks++; if (d_ready[m] !== 4'b0001) begin n_fail++; $display("FAIL release_ready[%0d]: got %b want 0001", m, d_ready[m]); end
        end
        tick();
        n_checks++; if (d_valid[0] !== 1'b1 || d_sel[0] !== 2'd0 || d_data[0] !== 8'h30) begin
            n_fail++; $display("FAIL release_beat: got v=%b sel=%0d data=%h want v=1 sel=0 data=30", d_valid[0], d_sel[0], d_data[0]);
        end
        in_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_single();
        do_reset();
        in_valid = '0; in_last = '1; out_ready = 1'b1;
        set_ch(2, 8'h5A, 1'b1, 1'b1);
        #1;
        n_checks++; if (d_ready[0] !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", d_ready[0]); end
        tick();
        set_ch(2, 8'h5A, 1'b0, 1'b1);
        #1;
        n_checks++; if (d_valid[0] !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", d_valid[0]); end
        n_checks++; if (d_data[0] !== 8'h5A) begin n_fail++; $display("FAIL single_data: got %h want 5a", d_data[0]); end
        n_checks++; if (d_sel[0] !== 2'd2) begin n_fail++; $display("FAIL single_sel: got %0d want 2", d_sel[0]); end
        tick();
    endtask

    task automatic test_round_robin();
        int exp_sel [6] = '{0, 1, 2, 3, 0, 1};
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) set_ch(c, W'(8'h40 + c), 1'b1, 1'b1);
        for (int b = 0; b < 6; b++) begin
            #1;
            n_checks++; if (d_ready[0] !== 4'(1 << exp_sel[b])) begin n_fail++; $display("FAIL rr_ready[%0d]: got %b want ch%0d", b, d_ready[0], exp_sel[b]); end
            tick();
            n_checks++; if (d_valid[0] !== 1'b1 || d_sel[0] !== 2'(exp_sel[b]) || d_data[0] !== W'(8'h40 + exp_sel[b])) begin
                n_fail++; $display("FAIL rr_beat[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d", b, d_valid[0], d_sel[0], d_data[0], exp_sel[b]);
            end
        end
        in_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = '0; in_last = '1; out_ready = 1'b1;
        set_ch(1, 8'h11, 1'b1, 1'b1);
        tick();
        set_ch(1, 8'h11, 1'b0, 1'b1);
        set_ch(2, 8'h22, 1'b1, 1'b1);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (d_ready[0] !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, d_ready[0]); end
            tick();
            n_checks++; if (d_valid[0] !== 1'b1 || d_data[0] !== 8'h11) begin
                n_fail++; $display("FAIL bp_hold[%0d]: got v=%b data=%h want v=1 data=11", k, d_valid[0], d_data[0]);
            end
        end
        out_ready = 1'b1;
        #1;
        n_checks++; if (d_ready[0] !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0100", d_ready[0]); end
        tick();
        n_checks++; if (d_valid[0] !== 1'b1 || d_data[0] !== 8'h22 || d_sel[0] !== 2'd2) begin
            n_fail++; $display("FAIL bp_next_beat: got v=%b data=%h sel=%0d want v=1 data=22 sel=2", d_valid[0], d_data[0], d_sel[0]);
        end
        in_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        in_valid = '0; in_last = '1; out_ready = 1'b1;
        set_ch(0, 8'hA0, 1'b1, 1'b1);
        set_ch(3, 8'hA3, 1'b1, 1'b1);
        for (int b = 0; b < 5; b++) begin
            tick();
            n_checks++; if (d_valid[1] !== 1'b1 || d_sel[1] !== 2'd0 || d_data[1] !== 8'hA0) begin
                n_fail++; $display("FAIL fp_beat[%0d]: got v=%b sel=%0d data=%h want v=1 sel=0 data=a0", b, d_valid[1], d_sel[1], d_data[1]);
            end
        end
        set_ch(0, 8'hA0, 1'b0, 1'b1);
        tick();
        n_checks++; if (d_valid[1] !== 1'b1 || d_sel[1] !== 2'd3 || d_data[1] !== 8'hA3) begin
            n_fail++; $display("FAIL fp_drop0: got v=%b sel=%0d data=%h want v=1 sel=3 data=a3", d_valid[1], d_sel[1], d_data[1]);
        end
        in_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_packet_lock();
        int exp_sel [6];
        int bi [2];
        int seen [2];
        int got;
        exp_sel = LOCK_EN ? '{0, 0, 0, 1, 1, 1} : '{0, 1, 0, 1, 0, 1};
        bi = '{0, 0};
        seen = '{0, 0};
        got = 0;
        do_reset();
        in_valid = '0; in_last = '0; out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && got < 6; cyc++) begin
            for (int c = 0; c < 2; c++) set_ch(c, W'(c * 16 + bi[c]), bi[c] < 3, bi[c] == 2);
            tick();
            if (acc_ok && acc_ch < 2) bi[acc_ch]++;
            if (d_valid[0] && got < 6) begin
                n_checks++; if (d_sel[0] !== 2'(exp_sel[got]) || d_data[0] !== W'(exp_sel[got] * 16 + seen[exp_sel[got]])) begin
                    n_fail++; $display("FAIL pkt_beat[%0d]: got sel=%0d data=%h want sel=%0d data=%h", got, d_sel[0], d_data[0],
                                       exp_sel[got], W'(exp_sel[got] * 16 + seen[exp_sel[got]]));
                end
                if (d_sel[0] < 2) seen[d_sel[0]]++;
                got++;
            end
        end
        n_checks++; if (got !== 6) begin n_fail++; $display("FAIL pkt_timeout: got %0d beats want 6", got); end
        in_valid = '0;
        tick();
        tick();
    endtask

    task automatic test_random();
        bit           pend [N];
        logic [W-1:0] pd   [N];
        bit           pl   [N];
        for (int c = 0; c < N; c++) pend[c] = 1'b0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            Rst = ($urandom_range(0, 99) == 0);
            for (int c = 0; c < N; c++) begin
                if (!pend[c] && $urandom_range(0, 1) == 1) begin
                    pend[c] = 1'b1;
                    pd[c]   = W'($urandom);
                    pl[c]   = ($urandom_range(0, 2) == 0);
                end
                set_ch(c, pd[c], pend[c], pl[c]);
            end
            #1;
            model_eval();
            for (int m = 0; m < 2; m++) begin
                n_checks++; if (d_ready[m] !== e_ready[m]) begin n_fail++; $display("FAIL rand_ready[%0d] cyc %0d: got %b want %b", m, cyc, d_ready[m], e_ready[m]); end
                n_checks++; if (d_valid[m] !== m_valid[m]) begin n_fail++; $display("FAIL rand_valid[%0d] cyc %0d: got %b want %b", m, cyc, d_valid[m], m_valid[m]); end
                n_checks++; if (d_data[m] !== m_data[m]) begin n_fail++; $display("FAIL rand_data[%0d] cyc %0d: got %h want %h", m, cyc, d_data[m], m_data[m]); end
                n_checks++; if (d_last[m] !== m_last[m]) begin n_fail++; $display("FAIL rand_last[%0d] cyc %0d: got %b want %b", m, cyc, d_last[m], m_last[m]); end
                n_checks++; if (d_sel[m] !== m_sel[m]) begin n_fail++; $display("FAIL rand_sel[%0d] cyc %0d: got %0d want %0d", m, cyc, d_sel[m], m_sel[m]); end
            end
            tick();
            if (acc_ok) pend[acc_ch] = 1'b0;
        end
        Rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1;
        in_data = '0;
        in_valid = '0;
        in_last = '0;
        out_ready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_fixed_priority();
        test_packet_lock();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
